// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative binary-to-BCD converter using double dabble (shift-and-add-3).
// It takes one unsigned WIDTH-bit value and, WIDTH clocks later, produces DIGITS packed BCD digits
// plus an overflow flag. The handshake uses start, busy and a one-cycle done pulse.
// Optional build macro BIN_TO_BCD_BLANK_EN: when it is defined, leading zero digits of a
// non-overflowing result are written as 4'hF, so the downstream 7-segment decoder blanks them.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      entrada,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    acc, acc_adj, acc_nxt, result;
  logic             ovf_acc, ovf_nxt;
  logic [CW-1:0]    count;
  logic             accept, last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == SHIFT) && (count == CW'(1));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: every clocked process uses non-blocking (<=) assignments. All registers
    // therefore sample values from before the edge, and the order of statements does not matter.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. start is ignored while a conversion is running.
  always_comb begin
    // NOTE: the default assignment at the top covers every path, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state == SHIFT);
  end

  // One double-dabble step. First, every digit >= 5 is corrected by +3, with no carry between
  // digits. Then {acc, shreg} shifts left. A 1 leaving the top digit means the value needs more
  // than DIGITS digits. That bit is lost from acc, but the lower digits stay exact modulo
  // 10^DIGITS.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_nxt   = {acc_adj[BW-2:0], shreg[WIDTH-1]};
    shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
    ovf_nxt   = ovf_acc | acc_adj[BW-1];
  end

`ifdef BIN_TO_BCD_BLANK_EN
  logic seen_nz;

  // Leading-zero blanking of the final accumulator. Digit 0 is never blanked.
  // Overflowed results are passed through unchanged.
  always_comb begin
    result  = acc_nxt;
    seen_nz = 1'b0;
    if (!ovf_nxt) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (acc_nxt[4*i +: 4] != 4'd0) seen_nz = 1'b1;
        if (!seen_nz) result[4*i +: 4] = 4'hF;
      end
    end
  end
`else
  assign result = acc_nxt;
`endif

  // Conversion datapath: load on accept, then one step per SHIFT cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
      count   <= '0;
    end else if (accept) begin
      shreg   <= entrada;
      acc     <= '0;
      ovf_acc <= 1'b0;
      count   <= CW'(WIDTH);
    end else if (state == SHIFT) begin
      shreg   <= shreg_nxt;
      acc     <= acc_nxt;
      ovf_acc <= ovf_nxt;
      count   <= count - CW'(1);
    end
  end

  // Result registers. They update only on the final step, so bcd/overflow keep the last result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        bcd      <= result;
        overflow <= ovf_nxt;
      end
    end
  end

endmodule
